mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//   MEM stage of the RISC-V pipeline. Sits between the EX/MEM slot and the MEM/WB register.
//   Non-memory instructions pass straight through to MEM/WB.
//   Loads/stores run a req/ack handshake with a variable-latency data memory, with byte/half/word
//   lane steering and sign/zero extension. stall_o freezes the upstream stages while a transaction is open.
// PARAMETERS
//   DATA_MEMORY_DEPTH  128  data memory size in 32-bit words; byte addresses >= 4*DEPTH are out of range
//   TIMEOUT_CYCLES     16   max cycles in ACCESS without ack before the access is aborted (>=1)
// PORTS
//   clk                  in   1   clock, rising edge
//   reset                in   1   synchronous, active-high
//   valid_i              in   1   EX/MEM slot holds an instruction
//   mem_read_i           in   1   load
//   mem_write_i          in   1   store (mem_read_i & mem_write_i both high = illegal)
//   reg_write_i          in   1   instruction writes rd
//   mem_to_reg_i         in   1   1: WB data = load data, 0: WB data = ALU result
//   write_register_i     in   5   rd
//   funct3_i             in   3   access size/sign
//   alu_result_i         in   32  byte address, or the result for non-memory instructions
//   store_data_i         in   32  rs2 value
//   dmem_req_o           out  1   request, registered
//   dmem_we_o            out  1   1 = write
//   dmem_addr_o          out  32  word-aligned byte address {addr[31:2],2'b00}
//   dmem_wdata_o         out  32  lane-replicated store data
//   dmem_be_o            out  4   byte enables
//   dmem_ack_i           in   1   transaction complete; rdata valid in the same cycle
//   dmem_rdata_i         in   32  read word
//   stall_o              out  1   combinational; hold EX/MEM and all earlier stages
//   memwb_valid_o        out  1   MEM/WB register valid
//   memwb_reg_write_o    out  1   MEM/WB write enable
//   memwb_write_register_o out 5  MEM/WB rd
//   memwb_write_data_o   out  32  MEM/WB write data
//   fault_o              out  1   1-cycle pulse: misaligned, out-of-range, bad funct3, or illegal read+write
//   timeout_o            out  1   1-cycle pulse: ack not received within TIMEOUT_CYCLES
// BEHAVIOUR
//   Reset: state=IDLE, counter=0, and every output = 0, including memwb_* and dmem_*.
//     Reset takes priority in any state; reset during ACCESS drops dmem_req_o at that edge.
//   mem_op = valid_i & (mem_read_i | mem_write_i). ok = mem_op & no fault.
//   IDLE:
//     - valid_i & !mem_op: capture into MEM/WB at the next edge:
//       valid=1, reg_write=reg_write_i, rd=write_register_i, data=alu_result_i. Latency 1, no stall.
//     - ok: stall_o=1. Latch dmem_* outputs and the WB fields. Next state ACCESS; memwb_valid_o=0 next cycle.
//     - mem_op & fault: no request. MEM/WB gets valid=1, reg_write=0. fault_o=1 the next cycle.
//     - !valid_i: memwb_valid_o=0 and memwb_reg_write_o=0 next cycle.
//   ACCESS: dmem_req_o=1; all dmem_* outputs held stable.
//     - stall_o = !dmem_ack_i.
//     - On ack: clear req, capture MEM/WB, state=IDLE.
//       Loads: reg_write=reg_write_i, data=mem_to_reg_i ? extended load : alu_result.
//       Stores: reg_write=0.
//     - Minimum memory-op latency: 2 cycles when ack is high in the first ACCESS cycle.
//     - Counter increments each ACCESS cycle without ack. If the counter reaches TIMEOUT_CYCLES:
//       drop req, timeout_o=1, MEM/WB valid=1 with reg_write=0, state=IDLE, and stall_o=0 that cycle.
//   dmem_ack_i is ignored in IDLE.
//   funct3:
//     - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//     - Store: 000 SB, 001 SH, 010 SW. Any other code = fault.
//   Alignment:
//     - Half-word access needs addr[0]=0; word access needs addr[1:0]=00; otherwise fault.
//     - Address >= 4*DATA_MEMORY_DEPTH = fault.
//   Lanes: byte k = rdata[8k+7:8k], k=addr[1:0]; half-word = rdata[16*addr[1]+:16].
//     LB/LH sign-extend; LBU/LHU zero-extend.
//   Stores:
//     - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
//     - SH: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
//     - SW: be=1111. Loads drive be=1111, we=0.
//   Width of the counter is $clog2(TIMEOUT_CYCLES+1) bits. It is cleared on entry to ACCESS.
// TESTING
//   addi pass-through (valid, rd=5, alu=0x2A) -> next cycle memwb_valid=1, reg_write=1, rd=5, data=0x2A, stall never high
//   LB addr=0x13, ack on the 3rd ACCESS cycle, rdata=0x80FF_0000 -> addr_o=0x10, stall high for 3 cycles, data=0xFFFF_FF80; LBU variant -> 0x0000_0080
//   SH addr=0x22, d=0x1234_ABCD -> be=1100, wdata=0xABCD_ABCD, we=1, memwb reg_write=0
//   LW addr=0x06 -> fault_o pulse, dmem_req_o never asserts, memwb valid=1 with reg_write=0; LW addr=0x200 with DEPTH=128 -> fault_o
//   ACCESS with no ack, TIMEOUT_CYCLES=16 -> req high for 16 cycles, timeout_o pulse, return to IDLE, stall_o falls
//   reset asserted in the 2nd ACCESS cycle -> next cycle dmem_req_o=0, stall_o=0, all memwb_*=0; a late ack is ignored

Source files
------------

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data memory request/acknowledge bus between the MEM stage and data memory
interface mem_access_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wdata_o,
    output dmem_be_o,
    input  dmem_ack_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wdata_o,
    input  dmem_be_o,
    output dmem_ack_i,
    output dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V MEM stage: pass-through, load/store handshake, lane steering, fault/timeout
module mem_access_stage #(
  parameter int DATA_MEMORY_DEPTH = 128,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic                reg_write_i,
  input  logic                mem_to_reg_i,
  input  logic [4:0]          write_register_i,
  input  logic [2:0]          funct3_i,
  input  logic [31:0]         alu_result_i,
  input  logic [31:0]         store_data_i,
  mem_access_stage_if.master  dmem,
  output logic                stall_o,
  output logic                memwb_valid_o,
  output logic                memwb_reg_write_o,
  output logic [4:0]          memwb_write_register_o,
  output logic [31:0]         memwb_write_data_o,
  output logic                fault_o,
  output logic                timeout_o
);
  localparam int              CW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [31:0]     ADDR_LIMIT = 32'(4 * DATA_MEMORY_DEPTH);
  localparam logic [0:0]      S_IDLE     = 1'b0;
  localparam logic [0:0]      S_ACCESS   = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_memwb_valid;
  logic          r_memwb_reg_write;
  logic [4:0]    r_memwb_rd;
  logic [31:0]   r_memwb_data;
  logic          r_fault;
  logic          r_timeout;
  logic          r_is_load;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic          r_lat_reg_write;
  logic          r_lat_mem_to_reg;
  logic [4:0]    r_lat_rd;
  logic [31:0]   r_lat_alu;

  logic          w_mem_op;
  logic          w_illegal;
  logic          w_bad_funct3;
  logic          w_misaligned;
  logic          w_out_of_range;
  logic          w_fault;
  logic          w_ok;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic          w_ack;
  logic          w_timeout_hit;

  // Request decode and store lane steering, evaluated against the EX/MEM slot in IDLE
  always_comb begin
    w_mem_op       = valid_i & (mem_read_i | mem_write_i);
    w_illegal      = mem_read_i & mem_write_i;
    w_bad_funct3   = 1'b0;
    w_misaligned   = 1'b0;
    w_out_of_range = (alu_result_i >= ADDR_LIMIT);
    if (mem_read_i) begin
      case (funct3_i)
        3'b000, 3'b100: w_misaligned = 1'b0;
        3'b001, 3'b101: w_misaligned = alu_result_i[0];
        3'b010:         w_misaligned = |alu_result_i[1:0];
        default:        w_bad_funct3 = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        3'b000:  w_misaligned = 1'b0;
        3'b001:  w_misaligned = alu_result_i[0];
        3'b010:  w_misaligned = |alu_result_i[1:0];
        default: w_bad_funct3 = 1'b1;
      endcase
    end
    w_fault = w_mem_op & (w_illegal | w_bad_funct3 | w_misaligned | w_out_of_range);
    w_ok    = w_mem_op & ~w_fault;

    w_wdata = 32'd0;
    w_be    = 4'b1111;
    if (mem_write_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_wdata = {4{store_data_i[7:0]}};
          w_be    = 4'b0001 << alu_result_i[1:0];
        end
        2'b01: begin
          w_wdata = {2{store_data_i[15:0]}};
          w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_wdata = store_data_i;
          w_be    = 4'b1111;
        end
      endcase
    end
  end

  // Load extraction uses the latched offset/size since the slot is frozen but not trusted
  always_comb begin
    w_byte = dmem.dmem_rdata_i[{r_off, 3'b000} +: 8];
    w_half = dmem.dmem_rdata_i[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem.dmem_rdata_i;
    endcase
  end

  always_comb begin
    w_ack         = dmem.dmem_ack_i;
    w_timeout_hit = (r_state == S_ACCESS) & ~w_ack & (r_cnt == CNT_LAST);
    if (r_state == S_IDLE) begin
      stall_o = w_ok;
    end else begin
      stall_o = ~w_ack & ~w_timeout_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_req             <= 1'b0;
      r_we              <= 1'b0;
      r_addr            <= 32'd0;
      r_wdata           <= 32'd0;
      r_be              <= 4'd0;
      r_memwb_valid     <= 1'b0;
      r_memwb_reg_write <= 1'b0;
      r_memwb_rd        <= 5'd0;
      r_memwb_data      <= 32'd0;
      r_fault           <= 1'b0;
      r_timeout         <= 1'b0;
      r_is_load         <= 1'b0;
      r_funct3          <= 3'd0;
      r_off             <= 2'd0;
      r_lat_reg_write   <= 1'b0;
      r_lat_mem_to_reg  <= 1'b0;
      r_lat_rd          <= 5'd0;
      r_lat_alu         <= 32'd0;
    end else begin
      r_fault   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!valid_i) begin
            r_memwb_valid     <= 1'b0;
            r_memwb_reg_write <= 1'b0;
          end else if (!w_mem_op) begin
            r_memwb_valid     <= 1'b1;
            r_memwb_reg_write <= reg_write_i;
            r_memwb_rd        <= write_register_i;
            r_memwb_data      <= alu_result_i;
          end else if (w_fault) begin
            r_memwb_valid     <= 1'b1;
            r_memwb_reg_write <= 1'b0;
            r_memwb_rd        <= write_register_i;
            r_memwb_data      <= alu_result_i;
            r_fault           <= 1'b1;
          end else begin
            r_memwb_valid     <= 1'b0;
            r_memwb_reg_write <= 1'b0;
            r_req             <= 1'b1;
            r_we              <= mem_write_i;
            r_addr            <= {alu_result_i[31:2], 2'b00};
            r_wdata           <= w_wdata;
            r_be              <= w_be;
            r_is_load         <= mem_read_i;
            r_funct3          <= funct3_i;
            r_off             <= alu_result_i[1:0];
            r_lat_reg_write   <= reg_write_i;
            r_lat_mem_to_reg  <= mem_to_reg_i;
            r_lat_rd          <= write_register_i;
            r_lat_alu         <= alu_result_i;
            r_cnt             <= '0;
            r_state           <= S_ACCESS;
          end
        end
        default: begin
          if (w_ack) begin
            r_req             <= 1'b0;
            r_memwb_valid     <= 1'b1;
            r_memwb_reg_write <= r_is_load & r_lat_reg_write;
            r_memwb_rd        <= r_lat_rd;
            r_memwb_data      <= (r_is_load & r_lat_mem_to_reg) ? w_load : r_lat_alu;
            r_state           <= S_IDLE;
          end else if (w_timeout_hit) begin
            r_cnt             <= r_cnt + CNT_ONE;
            r_req             <= 1'b0;
            r_timeout         <= 1'b1;
            r_memwb_valid     <= 1'b1;
            r_memwb_reg_write <= 1'b0;
            r_memwb_rd        <= r_lat_rd;
            r_state           <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign dmem.dmem_req_o      = r_req;
  assign dmem.dmem_we_o       = r_we;
  assign dmem.dmem_addr_o     = r_addr;
  assign dmem.dmem_wdata_o    = r_wdata;
  assign dmem.dmem_be_o       = r_be;
  assign memwb_valid_o          = r_memwb_valid;
  assign memwb_reg_write_o      = r_memwb_reg_write;
  assign memwb_write_register_o = r_memwb_rd;
  assign memwb_write_data_o     = r_memwb_data;
  assign fault_o                = r_fault;
  assign timeout_o              = r_timeout;
endmodule
